// File: rtl/tone_player.sv
// Square-wave note player: plays one half-period/duration request on the speaker
// pin, then holds a fixed silent gap before signalling done and taking the next note.
module tone_player #(
  parameter int CNT_W    = 18,
  parameter int DUR_W    = 16,
  parameter int MS_TICKS = 50000,
  parameter int GAP_MS   = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_comp,
  input  logic [DUR_W-1:0] req_dur_ms,
  input  logic             abort,
  output logic             speaker,
  output logic             busy,
  output logic             done
);

  localparam int PRE_W = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
  // one ms counter serves both the note length and the gap
  localparam int MS_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   comp_q, comp_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [CNT_W-1:0]   half_q, half_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [MS_W-1:0]    ms_q, ms_d;
  logic               spk_q, spk_d;
  logic               done_q, done_d;

  logic accept, ms_tick, play_end, gap_end;

  assign accept   = (state_q == S_IDLE) && req_valid && !abort;
  assign ms_tick  = (pre_q == PRE_W'(MS_TICKS - 1));
  assign play_end = ms_tick && (ms_q == MS_W'(dur_q) - MS_W'(1));
  assign gap_end  = ms_tick && (ms_q == MS_W'(GAP_MS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (req_dur_ms == '0) state_d = (GAP_MS == 0) ? S_IDLE : S_GAP;
        else                  state_d = S_PLAY;
      end
      S_PLAY: begin
        if (abort)         state_d = S_IDLE;
        else if (play_end) state_d = (GAP_MS == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (abort || gap_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    speaker   = spk_q;
    done      = done_q;
  end

  always_comb begin
    comp_d = comp_q;
    dur_d  = dur_q;
    half_d = half_q;
    pre_d  = pre_q;
    ms_d   = ms_q;
    spk_d  = spk_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        spk_d = 1'b0;
        if (accept) begin
          comp_d = req_comp;
          dur_d  = req_dur_ms;
          half_d = '0;
          pre_d  = '0;
          ms_d   = '0;
          if ((req_dur_ms == '0) && (GAP_MS == 0)) done_d = 1'b1;
        end
      end
      S_PLAY, S_GAP: begin
        pre_d = ms_tick ? '0 : pre_q + PRE_W'(1);
        if (ms_tick) ms_d = ms_q + MS_W'(1);
        // comp=0 is a rest: the wave stays low but timing runs as normal
        if ((state_q == S_PLAY) && (comp_q != '0)) begin
          if (half_q == comp_q - CNT_W'(1)) begin
            half_d = '0;
            spk_d  = ~spk_q;
          end else begin
            half_d = half_q + CNT_W'(1);
          end
        end
        if ((state_q == S_PLAY) && play_end) ms_d = '0;
        if (!abort && (((state_q == S_PLAY) && play_end && (GAP_MS == 0)) ||
                       ((state_q == S_GAP) && gap_end)))
          done_d = 1'b1;
      end
      default: ;
    endcase
    if (state_d != S_PLAY) spk_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      comp_q <= '0;
      dur_q  <= '0;
      half_q <= '0;
      pre_q  <= '0;
      ms_q   <= '0;
      spk_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      comp_q <= comp_d;
      dur_q  <= dur_d;
      half_q <= half_d;
      pre_q  <= pre_d;
      ms_q   <= ms_d;
      spk_q  <= spk_d;
      done_q <= done_d;
    end
  end

endmodule
